// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - hash table shared widths and command/head-pointer types
package hash_table;

    localparam int BUCKET_WIDTH     = 4;
    localparam int TABLE_ADDR_WIDTH = 5;
    localparam int KEY_WIDTH        = 8;

    typedef enum logic [1:0] {
        HT_FIND   = 2'd0,
        HT_INSERT = 2'd1,
        HT_DELETE = 2'd2,
        HT_UPDATE = 2'd3
    } ht_opcode_t;

    typedef struct packed {
        ht_opcode_t             opcode;
        logic [KEY_WIDTH-1:0]   key;
    } ht_cmd_t;

    typedef struct packed {
        ht_cmd_t                   cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
    } ht_hashed_task_t;

    typedef struct packed {
        logic [TABLE_ADDR_WIDTH-1:0] ptr;
        logic                        ptr_val;
    } head_ram_data_t;

    typedef struct packed {
        ht_cmd_t                     cmd;
        logic [BUCKET_WIDTH-1:0]     bucket;
        logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
        logic                        head_ptr_val;
    } ht_pdata_t;

endpackage

// File: rtl/head_ptr_fifo.sv
// rtl/head_ptr_fifo.sv - output buffer of fetched head pointers with per-entry snoop patching
module head_ptr_fifo
    import hash_table::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        push_i,
    input  ht_pdata_t                   push_data_i,
    input  logic                        pop_i,
    input  logic                        snoop_en_i,
    input  logic [BUCKET_WIDTH-1:0]     snoop_bucket_i,
    input  logic [TABLE_ADDR_WIDTH-1:0] snoop_ptr_i,
    input  logic                        snoop_ptr_val_i,
    output ht_pdata_t                   head_o,
    output logic                        head_valid_o,
    output logic [CNT_W-1:0]            used_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ht_pdata_t          mem [DEPTH];
    logic [DEPTH-1:0]   ent_valid;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            ent_valid <= '0;
        end else begin
            // Every queued entry of the written bucket tracks the table, head included
            for (int i = 0; i < DEPTH; i++) begin
                if (snoop_en_i && ent_valid[i] && mem[i].bucket == snoop_bucket_i) begin
                    mem[i].head_ptr     <= snoop_ptr_i;
                    mem[i].head_ptr_val <= snoop_ptr_val_i;
                end
            end
            if (push_i) begin
                mem[wr_ptr]       <= push_data_i;
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop_i) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= ptr_inc(rd_ptr);
            end
            case ({push_i, pop_i})
                2'b10:   used <= used + CNT_W'(1);
                2'b01:   used <= used - CNT_W'(1);
                default: used <= used;
            endcase
        end
    end

    assign head_valid_o = (used != '0);
    assign head_o       = head_valid_o ? mem[rd_ptr] : '0;
    assign used_o       = used;

endmodule

// File: rtl/head_ptr_fetch.sv
// rtl/head_ptr_fetch.sv - reads bucket head pointers from the head RAM with write snooping and credit flow control
module head_ptr_fetch
    import hash_table::ht_hashed_task_t, hash_table::head_ram_data_t, hash_table::ht_pdata_t,
           hash_table::TABLE_ADDR_WIDTH;
#(
    parameter int RAM_LATENCY  = 2,
    parameter int BUCKET_WIDTH = hash_table::BUCKET_WIDTH,
    parameter int FIFO_DEPTH   = RAM_LATENCY + 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  ht_hashed_task_t             task_i,
    input  logic                        task_valid_i,
    output logic                        task_ready_o,
    output logic [BUCKET_WIDTH-1:0]     rd_addr_o,
    output logic                        rd_en_o,
    input  head_ram_data_t              rd_data_i,
    input  logic                        snoop_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0]     snoop_wr_addr_i,
    input  logic [TABLE_ADDR_WIDTH-1:0] snoop_wr_ptr_i,
    input  logic                        snoop_wr_ptr_val_i,
    output ht_pdata_t                   pdata_o,
    output logic                        pdata_valid_o,
    input  logic                        pdata_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(RAM_LATENCY + 1);
    localparam int LAST  = RAM_LATENCY - 1;

    logic [RAM_LATENCY-1:0] stg_valid;
    logic [RAM_LATENCY-1:0] stg_ovr;
    logic [RAM_LATENCY-1:0] stg_hit;
    ht_hashed_task_t        stg_task [RAM_LATENCY];
    head_ram_data_t         stg_data [RAM_LATENCY];

    logic [IF_W-1:0]        in_flight;
    logic [CNT_W-1:0]       fifo_used;
    logic [CNT_W:0]         credits_used;
    logic                   accept;
    logic                   accept_hit;
    logic                   push;
    logic                   pop;
    head_ram_data_t         snoop_data;
    head_ram_data_t         ret_data;
    ht_pdata_t              push_data;
    ht_pdata_t              fifo_head;
    logic                   fifo_valid;

    assign snoop_data = '{ptr: snoop_wr_ptr_i, ptr_val: snoop_wr_ptr_val_i};

    always_comb begin
        credits_used  = (CNT_W + 1)'(fifo_used) + (CNT_W + 1)'(in_flight);
        task_ready_o  = rst_n_i && (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
        accept        = task_valid_i && task_ready_o;
        rd_en_o       = accept;
        rd_addr_o     = accept ? task_i.bucket : '0;
        // The RAM returns pre-write data on read-during-write, so an accept-cycle write must override
        accept_hit    = snoop_wr_en_i && (snoop_wr_addr_i == task_i.bucket);
        stg_hit       = '0;
        for (int k = 0; k < RAM_LATENCY; k++) begin
            stg_hit[k] = snoop_wr_en_i && stg_valid[k] && (stg_task[k].bucket == snoop_wr_addr_i);
        end
        push          = stg_valid[LAST];
        ret_data      = stg_hit[LAST] ? snoop_data :
                        stg_ovr[LAST] ? stg_data[LAST] : rd_data_i;
        push_data     = '{cmd:          stg_task[LAST].cmd,
                          bucket:       stg_task[LAST].bucket,
                          head_ptr:     ret_data.ptr,
                          head_ptr_val: ret_data.ptr_val};
        pdata_valid_o = rst_n_i && fifo_valid;
        pdata_o       = rst_n_i ? fifo_head : '0;
        pop           = pdata_valid_o && pdata_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stg_valid <= '0;
            stg_ovr   <= '0;
            in_flight <= '0;
        end else begin
            stg_valid[0] <= accept;
            stg_task[0]  <= task_i;
            stg_ovr[0]   <= accept && accept_hit;
            stg_data[0]  <= snoop_data;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_task[k]  <= stg_task[k-1];
                stg_ovr[k]   <= stg_ovr[k-1] | stg_hit[k-1];
                stg_data[k]  <= stg_hit[k-1] ? snoop_data : stg_data[k-1];
            end
            case ({accept, push})
                2'b10:   in_flight <= in_flight + IF_W'(1);
                2'b01:   in_flight <= in_flight - IF_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    head_ptr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .push_i          (push),
        .push_data_i     (push_data),
        .pop_i           (pop),
        .snoop_en_i      (snoop_wr_en_i),
        .snoop_bucket_i  (snoop_wr_addr_i),
        .snoop_ptr_i     (snoop_wr_ptr_i),
        .snoop_ptr_val_i (snoop_wr_ptr_val_i),
        .head_o          (fifo_head),
        .head_valid_o    (fifo_valid),
        .used_o          (fifo_used)
    );

endmodule

// File: tb/tb_head_ptr_fetch.sv
// tb/tb_head_ptr_fetch.sv - scoreboard bench for head_ptr_fetch with a 2-cycle head RAM model
module tb_head_ptr_fetch;
    import hash_table::*;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    ht_hashed_task_t task_i = '0;
    logic            task_valid_i = 1'b0;
    logic            task_ready_o;
    logic [3:0]      rd_addr_o;
    logic            rd_en_o;
    head_ram_data_t  rd_data_i;
    logic            snoop_wr_en_i = 1'b0;
    logic [3:0]      snoop_wr_addr_i = '0;
    logic [4:0]      snoop_wr_ptr_i = '0;
    logic            snoop_wr_ptr_val_i = 1'b0;
    ht_pdata_t       pdata_o;
    logic            pdata_valid_o;
    logic            pdata_ready_i = 1'b0;

    head_ptr_fetch dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .task_i             (task_i),
        .task_valid_i       (task_valid_i),
        .task_ready_o       (task_ready_o),
        .rd_addr_o          (rd_addr_o),
        .rd_en_o            (rd_en_o),
        .rd_data_i          (rd_data_i),
        .snoop_wr_en_i      (snoop_wr_en_i),
        .snoop_wr_addr_i    (snoop_wr_addr_i),
        .snoop_wr_ptr_i     (snoop_wr_ptr_i),
        .snoop_wr_ptr_val_i (snoop_wr_ptr_val_i),
        .pdata_o            (pdata_o),
        .pdata_valid_o      (pdata_valid_o),
        .pdata_ready_i      (pdata_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Head RAM: preload ptr=bucket+16, val=1; reads return pre-write data two cycles later
    head_ram_data_t ram [16];
    head_ram_data_t rd_p1 = '0;
    head_ram_data_t rd_p2 = '0;
    bit             ram_loaded = 1'b0;
    assign rd_data_i = rd_p2;

    always @(posedge clk_i) begin
        if (!ram_loaded) begin
            for (int b = 0; b < 16; b++) ram[b] <= '{ptr: 5'(b + 16), ptr_val: 1'b1};
            ram_loaded <= 1'b1;
        end else begin
            rd_p1 <= rd_en_o ? ram[rd_addr_o] : '0;
            rd_p2 <= rd_p1;
            if (snoop_wr_en_i) ram[snoop_wr_addr_i] <= '{ptr: snoop_wr_ptr_i, ptr_val: snoop_wr_ptr_val_i};
        end
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        ht_pdata_t pd;
        int        acc;
        bit        lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ht_hashed_task_t mk(input int b);
        ht_hashed_task_t t;
        t.cmd.opcode = ht_opcode_t'(b[1:0]);
        t.cmd.key    = 8'(b * 3 + 1);
        t.bucket     = 4'(b);
        return t;
    endfunction

    task automatic snoop(input int b, input int p, input logic v);
        snoop_wr_en_i      = 1'b1;
        snoop_wr_addr_i    = 4'(b);
        snoop_wr_ptr_i     = 5'(p);
        snoop_wr_ptr_val_i = v;
    endtask

    // One cycle: on accept, queue the hand-computed final head pointer for that task
    task automatic step(input int eptr, input logic eval, input bit lat);
        exp_t e;
        #1;
        if (task_valid_i && task_ready_o) begin
            chk("rd_en", rd_en_o, 1);
            chk("rd_addr", rd_addr_o, task_i.bucket);
            e.pd  = '{cmd: task_i.cmd, bucket: task_i.bucket, head_ptr: 5'(eptr), head_ptr_val: eval};
            e.acc = cyc;
            e.lat = lat;
            sb.push_back(e);
            n_acc++;
        end else begin
            chk("rd_en_idle", rd_en_o, 0);
        end
        @(negedge clk_i);
        snoop_wr_en_i = 1'b0;
    endtask

    logic      prev_hold = 1'b0;
    logic      prev_snoop = 1'b0;
    ht_pdata_t prev_pd = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_n_i) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && !prev_snoop) begin
                    chk("hold_valid", pdata_valid_o, 1);
                    chk("hold_data", pdata_o, prev_pd);
                end
                if (pdata_valid_o && pdata_ready_i) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected none (cycle %0d)", pdata_o, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("pdata", pdata_o, e.pd);
                        if (e.lat) chk("latency", cyc - e.acc, 3);
                    end
                end
                if (sb.size() > 4) begin
                    errors++;
                    $display("FAIL credit_overflow: got %0d outstanding expected at most 4", sb.size());
                end
                prev_hold = pdata_valid_o && !pdata_ready_i;
            end
            prev_pd    = pdata_o;
            prev_snoop = snoop_wr_en_i;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int nb;
        ht_hashed_task_t t;
        ht_pdata_t       q;

        // Reset values, with a task offered to prove rd_en stays low
        task_valid_i = 1'b1;
        task_i       = mk(1);
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_task_ready", task_ready_o, 0);
        chk("rst_rd_en", rd_en_o, 0);
        chk("rst_pdata_valid", pdata_valid_o, 0);
        chk("rst_pdata", pdata_o, 0);
        @(negedge clk_i);
        rst_n_i      = 1'b1;
        task_valid_i = 1'b0;
        #1;
        chk("release_ready", task_ready_o, 1);
        @(negedge clk_i);

        // Streaming: buckets 0..7 back to back, latency 3
        pdata_ready_i = 1'b1;
        a0 = n_acc;
        for (int b = 0; b < 8; b++) begin
            task_valid_i = 1'b1;
            task_i       = mk(b);
            step(b + 16, 1'b1, 1'b1);
        end
        task_valid_i = 1'b0;
        chk("stream_accepts", n_acc - a0, 8);
        repeat (5) step(0, 1'b0, 1'b0);

        // Backpressure: exactly 4 credits, then resume without loss
        pdata_ready_i = 1'b0;
        a0 = n_acc;
        nb = 8;
        task_valid_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            task_i = mk(nb);
            step(nb + 16, 1'b1, 1'b0);
            nb = 8 + n_acc - a0;
        end
        chk("bp_accepts", n_acc - a0, 4);
        chk("bp_ready", task_ready_o, 0);
        pdata_ready_i = 1'b1;
        for (int c = 0; c < 30 && nb < 16; c++) begin
            task_i = mk(nb);
            step(nb + 16, 1'b1, 1'b0);
            nb = 8 + n_acc - a0;
        end
        task_valid_i = 1'b0;
        chk("bp_total", n_acc - a0, 8);
        repeat (6) step(0, 1'b0, 1'b0);

        // Snoop in flight: table bucket 5 = {3,1}, then written {9,0} one cycle after accept
        snoop(5, 3, 1'b1);
        step(0, 1'b0, 1'b0);
        task_valid_i = 1'b1;
        task_i       = mk(5);
        step(9, 1'b0, 1'b1);
        task_valid_i = 1'b0;
        snoop(5, 9, 1'b0);
        step(0, 1'b0, 1'b0);
        repeat (4) step(0, 1'b0, 1'b0);

        // Return-cycle snoop on bucket 3; two snoops on bucket 4, latest wins
        task_valid_i = 1'b1;
        task_i       = mk(3);
        step(1, 1'b0, 1'b1);
        task_i = mk(4);
        snoop(4, 2, 1'b1);
        step(6, 1'b1, 1'b1);
        task_valid_i = 1'b0;
        snoop(3, 1, 1'b0);
        step(0, 1'b0, 1'b0);
        snoop(4, 6, 1'b1);
        step(0, 1'b0, 1'b0);
        repeat (4) step(0, 1'b0, 1'b0);

        // Accept-cycle snoop on bucket 2, then patch the presented head under backpressure
        pdata_ready_i = 1'b0;
        task_valid_i  = 1'b1;
        t             = mk(2);
        task_i        = t;
        snoop(2, 7, 1'b1);
        step(11, 1'b0, 1'b0);
        task_valid_i = 1'b0;
        repeat (3) step(0, 1'b0, 1'b0);
        q = '{cmd: t.cmd, bucket: 4'd2, head_ptr: 5'd7, head_ptr_val: 1'b1};
        chk("queued_valid", pdata_valid_o, 1);
        chk("queued_accept_snoop", pdata_o, q);
        snoop(2, 11, 1'b0);
        step(0, 1'b0, 1'b0);
        q = '{cmd: t.cmd, bucket: 4'd2, head_ptr: 5'd11, head_ptr_val: 1'b0};
        chk("queued_patched", pdata_o, q);
        pdata_ready_i = 1'b1;
        repeat (3) step(0, 1'b0, 1'b0);

        // Reset with 2 queued and 2 in flight; nothing stale may emerge
        pdata_ready_i = 1'b0;
        task_valid_i  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            task_i = mk(8 + c);
            step(24 + c, 1'b1, 1'b0);
        end
        task_valid_i = 1'b0;
        chk("pre_reset_valid", pdata_valid_o, 1);
        rst_n_i = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_ready", task_ready_o, 0);
        chk("mid_rst_rd_en", rd_en_o, 0);
        chk("mid_rst_valid", pdata_valid_o, 0);
        chk("mid_rst_pdata", pdata_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("post_rst_ready", task_ready_o, 1);
        chk("post_rst_valid", pdata_valid_o, 0);
        @(negedge clk_i);
        pdata_ready_i = 1'b1;
        repeat (8) step(0, 1'b0, 1'b0);
        task_valid_i = 1'b1;
        task_i       = mk(12);
        step(28, 1'b1, 1'b1);
        task_valid_i = 1'b0;
        repeat (5) step(0, 1'b0, 1'b0);

        chk("drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
